// File: rtl/tcdm_arbiter_nx1.sv
// N-to-1 TCDM arbiter: round-robin with request locking and an ID FIFO that routes responses back.
// Optional: define TCDM_ARB_FIXED_PRIO_EN for legacy fixed priority (lowest index wins).
module tcdm_arbiter_nx1 #(
    parameter int N_MASTERS       = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [N_MASTERS-1:0]                  m_req_i,
    input  logic [N_MASTERS-1:0][ADDR_WIDTH-1:0]  m_add_i,
    input  logic [N_MASTERS-1:0]                  m_wen_i,
    input  logic [N_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata_i,
    input  logic [N_MASTERS-1:0][BE_WIDTH-1:0]    m_be_i,
    output logic [N_MASTERS-1:0]                  m_gnt_o,
    output logic [N_MASTERS-1:0]                  m_r_valid_o,
    output logic [N_MASTERS-1:0][DATA_WIDTH-1:0]  m_r_rdata_o,
    output logic                                  s_req_o,
    output logic [ADDR_WIDTH-1:0]                 s_add_o,
    output logic                                  s_wen_o,
    output logic [DATA_WIDTH-1:0]                 s_wdata_o,
    output logic [BE_WIDTH-1:0]                   s_be_o,
    input  logic                                  s_gnt_i,
    input  logic                                  s_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                 s_r_rdata_i
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [IDX_W-1:0] rr_ptr_reg;
    logic             lock_vld_reg;
    logic [IDX_W-1:0] lock_idx_reg;

    logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic [IDX_W-1:0] sel;
    logic             any_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             handshake;
    logic             pop;
    logic [IDX_W-1:0] head;
    int               cand;

    assign any_req    = |m_req_i;
    assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_reg == '0);
    assign head       = fifo_mem[rd_ptr_reg];

    // A locked master keeps the slave port until granted or until it drops its request.
    always_comb begin
        sel  = '0;
        cand = 0;
        if (lock_vld_reg && m_req_i[lock_idx_reg]) begin
            sel = lock_idx_reg;
        end else begin
            for (int k = N_MASTERS - 1; k >= 0; k--) begin
                cand = (int'(rr_ptr_reg) + k) % N_MASTERS;
                if (m_req_i[cand]) begin
                    sel = IDX_W'(cand);
                end
            end
        end
    end

    // Full-FIFO gating uses only registered state, so r_valid never reaches s_req_o.
    assign s_req_o   = any_req & ~fifo_full;
    assign s_add_o   = m_add_i[sel];
    assign s_wen_o   = m_wen_i[sel];
    assign s_wdata_o = m_wdata_i[sel];
    assign s_be_o    = m_be_i[sel];
    assign handshake = s_req_o & s_gnt_i;
    assign pop       = s_r_valid_i & ~fifo_empty;

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
            assign m_gnt_o[gi]     = handshake && (sel == IDX_W'(gi));
            assign m_r_valid_o[gi] = pop && (head == IDX_W'(gi));
            assign m_r_rdata_o[gi] = s_r_rdata_i;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_mem[wr_ptr_reg] <= sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (handshake) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (handshake && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !handshake) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_vld_reg <= 1'b0;
            lock_idx_reg <= '0;
        end else if (handshake) begin
            lock_vld_reg <= 1'b0;
        end else if (any_req) begin
            lock_vld_reg <= 1'b1;
            lock_idx_reg <= sel;
        end else begin
            lock_vld_reg <= 1'b0;
        end
    end

`ifdef TCDM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= '0;
        end
    end
`else
    logic [IDX_W-1:0] rr_next;
    assign rr_next = (sel == IDX_W'(N_MASTERS - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_reg <= '0;
        end else if (handshake) begin
            rr_ptr_reg <= rr_next;
        end
    end
`endif

endmodule

// File: tb/tb_tcdm_arbiter_nx1.sv
// Self-checking bench for tcdm_arbiter_nx1 (N=4, MAX_OUTSTANDING=2): directed scenarios plus a
// randomized run against a queue-based model of the arbitration rules.
module tb_tcdm_arbiter_nx1;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 2;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [N-1:0]          m_req_i;
    logic [N-1:0][AW-1:0]  m_add_i;
    logic [N-1:0]          m_wen_i;
    logic [N-1:0][DW-1:0]  m_wdata_i;
    logic [N-1:0][BW-1:0]  m_be_i;
    logic [N-1:0]          m_gnt_o;
    logic [N-1:0]          m_r_valid_o;
    logic [N-1:0][DW-1:0]  m_r_rdata_o;
    logic                  s_req_o;
    logic [AW-1:0]         s_add_o;
    logic                  s_wen_o;
    logic [DW-1:0]         s_wdata_o;
    logic [BW-1:0]         s_be_o;
    logic                  s_gnt_i;
    logic                  s_r_valid_i;
    logic [DW-1:0]         s_r_rdata_i;

    tcdm_arbiter_nx1 #(
        .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_add_i(m_add_i), .m_wen_i(m_wen_i), .m_wdata_i(m_wdata_i),
        .m_be_i(m_be_i), .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o), .m_r_rdata_o(m_r_rdata_o),
        .s_req_o(s_req_o), .s_add_o(s_add_o), .s_wen_o(s_wen_o), .s_wdata_o(s_wdata_o),
        .s_be_o(s_be_o), .s_gnt_i(s_gnt_i), .s_r_valid_i(s_r_valid_i), .s_r_rdata_i(s_r_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Reference model: who is next in line, who holds the lock, and a queue of issuers awaiting a response.
    int rr_m;
    bit lock_v_m;
    int lock_i_m;
    int q_m[$];
    logic [N-1:0] cur_req;
    int e_sel;
    bit e_sreq, e_hs, e_pop;
    logic [N-1:0] e_gnt, e_rv;

    function automatic int pick(input logic [N-1:0] req);
        if (lock_v_m && req[lock_i_m]) return lock_i_m;
        for (int k = 0; k < N; k++) begin
            if (req[(rr_m + k) % N]) return (rr_m + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        rr_m = 0;
        lock_v_m = 0;
        lock_i_m = 0;
        q_m.delete();
    endtask

    // Drive one cycle's inputs and work out what the outputs must be; leaves time mid-cycle.
    task automatic set_in(input logic [N-1:0] req, input bit gnt, input bit rv, input logic [DW-1:0] rd);
        m_req_i = req;
        s_gnt_i = gnt;
        s_r_valid_i = rv;
        s_r_rdata_i = rd;
        for (int i = 0; i < N; i++) begin
            m_add_i[i]   = $urandom;
            m_wdata_i[i] = $urandom;
            m_be_i[i]    = BW'($urandom);
            m_wen_i[i]   = 1'($urandom);
        end
        cur_req = req;
        e_sel  = pick(req);
        e_sreq = (req != 0) && (q_m.size() < MO);
        e_hs   = e_sreq && gnt;
        e_pop  = rv && (q_m.size() > 0);
        e_gnt  = e_hs ? N'(1 << e_sel) : '0;
        e_rv   = e_pop ? N'(1 << q_m[0]) : '0;
        #3;
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (e_pop) void'(q_m.pop_front());
        if (e_hs) begin
            q_m.push_back(e_sel);
`ifndef TCDM_ARB_FIXED_PRIO_EN
            rr_m = (e_sel + 1) % N;
`endif
            lock_v_m = 0;
        end else if (cur_req != 0) begin
            lock_v_m = 1;
            lock_i_m = e_sel;
        end else begin
            lock_v_m = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        m_req_i = '0; s_gnt_i = 0; s_r_valid_i = 0; s_r_rdata_i = '0;
        m_add_i = '0; m_wdata_i = '0; m_be_i = '0; m_wen_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        m_req_i = '0; s_gnt_i = 1; s_r_valid_i = 0; s_r_rdata_i = '0;
        m_add_i = '0; m_wdata_i = '0; m_be_i = '0; m_wen_i = '0;
        model_reset();
        #3;
        checks++;
        if ({s_req_o, m_gnt_o, m_r_valid_o} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b gnt=%b rv=%b want all 0", s_req_o, m_gnt_o, m_r_valid_o);
        end
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        set_in(4'b1111, 1, 0, '0);
        checks++;
        if (m_gnt_o !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_grant got %b want 0001", m_gnt_o);
        end
        tick();
        $display("test_reset done");
    endtask

    task automatic test_rotation();
        logic [N-1:0] want;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_in(4'b1111, 1, 1, DW'(k));
`ifdef TCDM_ARB_FIXED_PRIO_EN
            want = 4'b0001;
`else
            want = N'(1 << (k % N));
`endif
            checks++;
            if (m_gnt_o !== want) begin
                failures++;
                $display("FAIL rotation cycle %0d gnt got %b want %b", k, m_gnt_o, want);
            end
            tick();
        end
        $display("test_rotation done");
    endtask

    task automatic test_lock();
        logic [AW-1:0] a2;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(4'b0100, 0, 0, '0);
            a2 = m_add_i[2];
            checks++;
            if (s_add_o !== a2 || m_gnt_o !== 4'b0) begin
                failures++;
                $display("FAIL lock_hold cycle %0d add=%h want %h gnt=%b", k, s_add_o, a2, m_gnt_o);
            end
            tick();
        end
        set_in(4'b0101, 0, 0, '0);
        a2 = m_add_i[2];
        checks++;
        if (s_add_o !== a2) begin
            failures++;
            $display("FAIL lock_vs_m0 add=%h want %h", s_add_o, a2);
        end
        tick();
        set_in(4'b0101, 1, 0, '0);
        checks++;
        if (m_gnt_o !== 4'b0100) begin
            failures++;
            $display("FAIL lock_grant got %b want 0100", m_gnt_o);
        end
        tick();
        set_in(4'b0101, 1, 1, '0);
        checks++;
        if (m_gnt_o !== 4'b0001 || m_r_valid_o !== 4'b0100) begin
            failures++;
            $display("FAIL lock_then_m0 gnt=%b want 0001 rv=%b want 0100", m_gnt_o, m_r_valid_o);
        end
        tick();
        $display("test_lock done");
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_in(4'b1111, 1, 0, '0);
            checks++;
            if (m_gnt_o !== e_gnt || !s_req_o) begin
                failures++;
                $display("FAIL full_fill %0d gnt=%b want %b sreq=%b", k, m_gnt_o, e_gnt, s_req_o);
            end
            tick();
        end
        set_in(4'b1111, 1, 0, '0);
        checks++;
        if (s_req_o !== 1'b0 || m_gnt_o !== 4'b0) begin
            failures++;
            $display("FAIL full_stall sreq=%b gnt=%b want 0/0000", s_req_o, m_gnt_o);
        end
        tick();
        set_in(4'b1111, 1, 1, 32'h55);
        checks++;
        if (m_r_valid_o !== 4'b0001 || s_req_o !== 1'b0 || m_gnt_o !== 4'b0) begin
            failures++;
            $display("FAIL full_pop rv=%b want 0001 sreq=%b want 0 gnt=%b", m_r_valid_o, s_req_o, m_gnt_o);
        end
        tick();
        set_in(4'b1111, 1, 0, '0);
        checks++;
        if (s_req_o !== 1'b1 || m_gnt_o !== e_gnt || e_gnt == 0) begin
            failures++;
            $display("FAIL full_resume sreq=%b gnt=%b want %b", s_req_o, m_gnt_o, e_gnt);
        end
        tick();
        $display("test_fifo_full done");
    endtask

    task automatic test_order();
        logic [N-1:0] want_rv [3] = '{4'b1000, 4'b0010, 4'b0100};
        logic [DW-1:0] rd [3] = '{32'hA, 32'hB, 32'hC};
        do_reset();
        set_in(4'b1000, 1, 0, '0);
        tick();
        set_in(4'b0010, 1, 0, '0);
        tick();
        set_in(4'b0100, 1, 1, rd[0]);
        checks++;
        if (m_r_valid_o !== want_rv[0] || m_r_rdata_o[3] !== rd[0] || m_gnt_o !== 4'b0) begin
            failures++;
            $display("FAIL order_0 rv=%b want %b rdata=%h gnt=%b", m_r_valid_o, want_rv[0], m_r_rdata_o[3], m_gnt_o);
        end
        tick();
        set_in(4'b0100, 1, 1, rd[1]);
        checks++;
        if (m_r_valid_o !== want_rv[1] || m_r_rdata_o[1] !== rd[1] || m_gnt_o !== 4'b0100) begin
            failures++;
            $display("FAIL order_1 rv=%b want %b rdata=%h gnt=%b want 0100", m_r_valid_o, want_rv[1], m_r_rdata_o[1], m_gnt_o);
        end
        tick();
        set_in(4'b0000, 0, 1, rd[2]);
        checks++;
        if (m_r_valid_o !== want_rv[2] || m_r_rdata_o[2] !== rd[2] || m_r_rdata_o[0] !== rd[2]) begin
            failures++;
            $display("FAIL order_2 rv=%b want %b rdata=%h want %h", m_r_valid_o, want_rv[2], m_r_rdata_o[2], rd[2]);
        end
        tick();
        $display("test_order done");
    endtask

    task automatic test_empty_rvalid();
        do_reset();
        set_in(4'b0000, 0, 1, 32'hDEAD);
        checks++;
        if (m_r_valid_o !== 4'b0 || s_req_o !== 1'b0) begin
            failures++;
            $display("FAIL empty_drop rv=%b sreq=%b want 0000/0", m_r_valid_o, s_req_o);
        end
        tick();
        set_in(4'b1111, 1, 0, '0);
        tick();
        set_in(4'b1111, 1, 0, '0);
        checks++;
        if (s_req_o !== 1'b1) begin
            failures++;
            $display("FAIL empty_count_second sreq=%b want 1", s_req_o);
        end
        tick();
        set_in(4'b1111, 1, 0, '0);
        checks++;
        if (s_req_o !== 1'b0) begin
            failures++;
            $display("FAIL empty_count_full sreq=%b want 0", s_req_o);
        end
        tick();
        $display("test_empty_rvalid done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(4'b1111, 1, 0, '0);
        tick();
        set_in(4'b1111, 1, 0, '0);
        tick();
        do_reset();
        set_in(4'b0000, 0, 1, 32'h1234);
        checks++;
        if (m_r_valid_o !== 4'b0) begin
            failures++;
            $display("FAIL reset_mid_drop rv=%b want 0000", m_r_valid_o);
        end
        tick();
        set_in(4'b1111, 1, 0, '0);
        checks++;
        if (m_gnt_o !== 4'b0001) begin
            failures++;
            $display("FAIL reset_mid_regrant gnt=%b want 0001", m_gnt_o);
        end
        tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int sel_m;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            set_in(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), $urandom);
            sel_m = $urandom_range(0, N - 1);
            checks++;
            if (s_req_o !== e_sreq || m_gnt_o !== e_gnt || m_r_valid_o !== e_rv) begin
                failures++;
                $display("FAIL rand_ctrl c=%0d sreq=%b/%b gnt=%b/%b rv=%b/%b (got/want)",
                         c, s_req_o, e_sreq, m_gnt_o, e_gnt, m_r_valid_o, e_rv);
            end
            if (cur_req != 0) begin
                checks++;
                if (s_add_o !== m_add_i[e_sel] || s_wdata_o !== m_wdata_i[e_sel] ||
                    s_be_o !== m_be_i[e_sel] || s_wen_o !== m_wen_i[e_sel]) begin
                    failures++;
                    $display("FAIL rand_mux c=%0d add=%h want %h (master %0d)", c, s_add_o, m_add_i[e_sel], e_sel);
                end
            end
            checks++;
            if (m_r_rdata_o[sel_m] !== s_r_rdata_i) begin
                failures++;
                $display("FAIL rand_rdata c=%0d port %0d got %h want %h", c, sel_m, m_r_rdata_o[sel_m], s_r_rdata_i);
            end
            tick();
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_lock();
        test_fifo_full();
        test_order();
        test_empty_rvalid();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
